nonce_search_ctrl: RTL and testbench

NONCE_SEARCH_CTRL -- requirements
Module: nonce_search_ctrl

---
 rtl/nonce_pkg.sv | 15 +
 rtl/nonce_cmp.sv | 12 +
 rtl/nonce_search_ctrl.sv | 146 ++++++++++++++
 tb/tb_nonce_search_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_pkg.sv
// Shared types and widths for the nonce search controller.
package nonce_pkg;

  localparam int NONCE_W = 32;
  localparam int HASH_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FOUND,
    DONE
  } state_t;

endpackage

// File: rtl/nonce_cmp.sv
// Hit detector: a digest word strictly below the target counts as a hit.
module nonce_cmp
  import nonce_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              hit
);

  assign hit = (hash < target);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Walks a nonce range through a single-outstanding hash core and reports the first hit.
// Optional feature: define NONCE_STATS_EN to add the saturating 'attempts' counter output.
module nonce_search_ctrl
  import nonce_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_limit,
  input  logic [HASH_W-1:0]  target,
  output logic               core_req,
  output logic [NONCE_W-1:0] core_nonce,
  input  logic               core_ready,
  input  logic               hash_valid,
  input  logic [HASH_W-1:0]  hash_in,
  output logic               valid,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               exhausted
`ifdef NONCE_STATS_EN
  ,
  output logic [31:0]        attempts
`endif
);

  state_t             state;
  state_t             state_d;
  logic [NONCE_W-1:0] cur;
  logic [NONCE_W-1:0] limit_q;
  logic [HASH_W-1:0]  target_q;
  logic               hit;
  logic               load;
  logic               advance;
  logic               exh_set;
  logic               exh_clr;

  nonce_cmp u_cmp (
    .hash   (hash_in),
    .target (target_q),
    .hit    (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Abort outranks everything, including a hit arriving in the same cycle.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    advance = 1'b0;
    exh_set = 1'b0;
    exh_clr = 1'b0;
    if (abort) begin
      state_d = IDLE;
      exh_clr = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_d = ISSUE;
            load    = 1'b1;
            exh_clr = 1'b1;
          end
        end
        ISSUE: begin
          if (core_ready) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (hash_valid) begin
            if (hit) begin
              state_d = FOUND;
            end else if (cur == limit_q) begin
              state_d = DONE;
              exh_set = 1'b1;
            end else begin
              state_d = ISSUE;
              advance = 1'b1;
            end
          end
        end
        FOUND: begin
          state_d = DONE;
          exh_clr = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= '0;
      limit_q   <= '0;
      target_q  <= '0;
      exhausted <= 1'b0;
    end else begin
      if (load) begin
        cur      <= nonce_start;
        limit_q  <= nonce_limit;
        target_q <= target;
      end else if (advance) begin
        cur <= cur + 32'd1;
      end
      if (exh_set) begin
        exhausted <= 1'b1;
      end else if (exh_clr) begin
        exhausted <= 1'b0;
      end
    end
  end

  // cur still holds the winning nonce while in FOUND because a hit never advances it.
  assign core_req   = (state == ISSUE);
  assign core_nonce = (state == ISSUE) ? cur : '0;
  assign busy       = (state == ISSUE) || (state == WAIT);
  assign valid      = (state == FOUND);
  assign nonce      = (state == FOUND) ? cur : '0;

`ifdef NONCE_STATS_EN
  logic hash_taken;

  assign hash_taken = !abort && (state == WAIT) && hash_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attempts <= '0;
    end else if (load) begin
      attempts <= '0;
    end else if (hash_taken && (attempts != 32'hFFFF_FFFF)) begin
      attempts <= attempts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Self-checking bench for nonce_search_ctrl: emulates the hash core and compares against a transaction-level model.
module tb_nonce_search_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] nonce_start;
  logic [31:0] nonce_limit;
  logic [31:0] target;
  logic        core_req;
  logic [31:0] core_nonce;
  logic        core_ready;
  logic        hash_valid;
  logic [31:0] hash_in;
  logic        valid;
  logic [31:0] nonce;
  logic        busy;
  logic        exhausted;
`ifdef NONCE_STATS_EN
  logic [31:0] attempts;
`endif

  nonce_search_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .nonce_start (nonce_start),
    .nonce_limit (nonce_limit),
    .target      (target),
    .core_req    (core_req),
    .core_nonce  (core_nonce),
    .core_ready  (core_ready),
    .hash_valid  (hash_valid),
    .hash_in     (hash_in),
    .valid       (valid),
    .nonce       (nonce),
    .busy        (busy),
    .exhausted   (exhausted)
`ifdef NONCE_STATS_EN
    ,
    .attempts    (attempts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Search-level model: a running search, whether its nonce is with the core, and any pending hit pulse.
  bit          mActive;
  bit          mOutstanding;
  bit          mPendValid;
  bit          mExh;
  logic [31:0] mNextNonce;
  logic [31:0] mLimit;
  logic [31:0] mTarget;
  logic [31:0] mPendNonce;
  logic [31:0] mAttempts;
  int          hvDelay;

  int          readyMode;
  int          hashMode;
  bit          randAbort;
  bit          randStart;
  logic [31:0] stNs;
  logic [31:0] stNl;
  logic [31:0] stTg;
  logic [31:0] reqLog[$];
  logic [31:0] pulseLog[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hashFor(input logic [31:0] n);
    logic [31:0] h;
    case (hashMode)
      0: begin
        case ($urandom_range(0, 4))
          0:       h = 32'h0;
          1:       h = 32'hFFFF_FFFF;
          2:       h = $urandom;
          3:       h = mTarget - 32'd1;
          default: h = mTarget;
        endcase
      end
      1:       h = 32'hFFFF_FFFF;
      2:       h = (n == 32'h12) ? 32'h0000_0FFF : 32'hFFFF_0000;
      3:       h = 32'h0;
      default: h = 32'hFFFF_FFFE;
    endcase
    return h;
  endfunction

  task automatic modelReset();
    mActive      = 1'b0;
    mOutstanding = 1'b0;
    mPendValid   = 1'b0;
    mExh         = 1'b0;
    mNextNonce   = 32'h0;
    mLimit       = 32'h0;
    mTarget      = 32'h0;
    mPendNonce   = 32'h0;
    mAttempts    = 32'h0;
  endtask

  task automatic modelStep();
    bit hitNow;
    hitNow = 1'b0;
    if (abort) begin
      mActive      = 1'b0;
      mOutstanding = 1'b0;
      mExh         = 1'b0;
    end else if (!mActive && !mPendValid && start) begin
      mActive      = 1'b1;
      mOutstanding = 1'b0;
      mNextNonce   = nonce_start;
      mLimit       = nonce_limit;
      mTarget      = target;
      mExh         = 1'b0;
      mAttempts    = 32'h0;
    end else if (mActive && !mOutstanding) begin
      if (core_ready) begin
        mOutstanding = 1'b1;
        hvDelay      = $urandom_range(0, 3);
      end
    end else if (mActive && mOutstanding && hash_valid) begin
      if (mAttempts != 32'hFFFF_FFFF) mAttempts = mAttempts + 32'd1;
      if (hash_in < mTarget) begin
        mActive    = 1'b0;
        hitNow     = 1'b1;
        mPendNonce = mNextNonce;
      end else if (mNextNonce == mLimit) begin
        mActive = 1'b0;
        mExh    = 1'b1;
      end else begin
        mNextNonce   = mNextNonce + 32'd1;
        mOutstanding = 1'b0;
      end
    end
    mPendValid = hitNow;
  endtask

  task automatic checkOutput();
    bit expReq;
    expReq = mActive && !mOutstanding;
    cmp("core_req", {31'b0, core_req}, {31'b0, expReq});
    if (expReq) cmp("core_nonce", core_nonce, mNextNonce);
    cmp("busy", {31'b0, busy}, {31'b0, mActive});
    cmp("valid", {31'b0, valid}, {31'b0, mPendValid});
    cmp("nonce", nonce, mPendValid ? mPendNonce : 32'h0);
    cmp("exhausted", {31'b0, exhausted}, {31'b0, mExh});
`ifdef NONCE_STATS_EN
    cmp("attempts", attempts, mAttempts);
`endif
    if (valid === 1'b1) pulseLog.push_back(nonce);
  endtask

  // hvCtl: 0 = core emulation drives hash_valid, 1 = force hash_valid with hvHash, 2 = hold hash_valid low.
  task automatic applyStimulus(input bit st, input bit ab, input int hvCtl, input logic [31:0] hvHash);
    bit stEff;
    bit abEff;
    stEff = st || (randStart && ($urandom_range(0, 29) == 0));
    abEff = ab || (randAbort && ($urandom_range(0, 59) == 0));
    if (st) begin
      nonce_start = stNs;
      nonce_limit = stNl;
      target      = stTg;
    end else begin
      nonce_start = $urandom;
      nonce_limit = stEff ? nonce_start + 32'($urandom_range(0, 4)) : $urandom;
      target      = $urandom;
    end
    start = stEff;
    abort = abEff;
    case (readyMode)
      0:       core_ready = ($urandom_range(0, 1) == 1);
      1:       core_ready = 1'b1;
      default: core_ready = 1'b0;
    endcase
    hash_valid = 1'b0;
    hash_in    = $urandom;
    if (hvCtl == 1) begin
      hash_valid = 1'b1;
      hash_in    = hvHash;
    end else if (hvCtl == 0) begin
      if (mActive && mOutstanding) begin
        if (hvDelay == 0) begin
          hash_valid = 1'b1;
          hash_in    = hashFor(mNextNonce);
        end else begin
          hvDelay--;
        end
      end else if (hashMode == 0 && $urandom_range(0, 9) == 0) begin
        hash_valid = 1'b1;
        hash_in    = $urandom_range(0, 15);
      end
    end
    if (core_req === 1'b1 && core_ready && !reset && !abEff) reqLog.push_back(core_nonce);
    if (reset) modelReset();
    else modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic startSearch(input logic [31:0] ns, input logic [31:0] nl, input logic [31:0] tg);
    stNs = ns;
    stNl = nl;
    stTg = tg;
    applyStimulus(1'b1, 1'b0, 0, 32'h0);
  endtask

  task automatic runUntilIdle(input int maxC);
    int c;
    c = 0;
    while ((mActive || mPendValid) && c < maxC) begin
      applyStimulus(1'b0, 1'b0, 0, 32'h0);
      c++;
    end
    if (mActive || mPendValid) begin
      checks++;
      failures++;
      $display("[TB] FAIL search_timeout actual=%0d cycles required=completion", c);
    end
  endtask

  task automatic clearLogs();
    reqLog.delete();
    pulseLog.delete();
  endtask

  task automatic checkReqs(input string tag, input int n,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e[4];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    e[3] = e3;
    cmp({tag, "_reqcount"}, 32'(reqLog.size()), 32'(n));
    for (int i = 0; i < n && i < reqLog.size(); i++) begin
      cmp($sformatf("%s_req%0d", tag, i), reqLog[i], e[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    nonce_start = 32'h0;
    nonce_limit = 32'h0;
    target      = 32'h0;
    core_ready  = 1'b0;
    hash_valid  = 1'b0;
    hash_in     = 32'h0;
    readyMode   = 1;
    hashMode    = 1;
    randAbort   = 1'b0;
    randStart   = 1'b0;
    hvDelay     = 0;
    modelReset();

    @(negedge clk);
    checkOutput();
    cmp("rst_core_req", {31'b0, core_req}, 32'h0);
    cmp("rst_busy", {31'b0, busy}, 32'h0);
    cmp("rst_valid", {31'b0, valid}, 32'h0);
    cmp("rst_nonce", nonce, 32'h0);
    cmp("rst_core_nonce", core_nonce, 32'h0);
    cmp("rst_exhausted", {31'b0, exhausted}, 32'h0);
    reset = 1'b0;

    // Hit on the third nonce.
    clearLogs();
    readyMode = 0;
    hashMode  = 2;
    startSearch(32'h10, 32'h13, 32'h1000);
    runUntilIdle(200);
    checkReqs("r036", 3, 32'h10, 32'h11, 32'h12, 32'h0);
    cmp("r036_pulses", 32'(pulseLog.size()), 32'd1);
    if (pulseLog.size() > 0) cmp("r036_nonce", pulseLog[0], 32'h12);
    cmp("r036_exhausted", {31'b0, exhausted}, 32'h0);

    // All misses over a short range.
    clearLogs();
    hashMode = 1;
    startSearch(32'h5, 32'h7, 32'h1000);
    runUntilIdle(200);
    checkReqs("r037", 3, 32'h5, 32'h6, 32'h7, 32'h0);
    cmp("r037_pulses", 32'(pulseLog.size()), 32'd0);
    cmp("r037_exhausted", {31'b0, exhausted}, 32'h1);
`ifdef NONCE_STATS_EN
    cmp("r041_attempts", attempts, 32'd3);
`endif
    startSearch(32'h30, 32'h31, 32'h1000);
`ifdef NONCE_STATS_EN
    cmp("r041_cleared", attempts, 32'd0);
`endif
    cmp("restart_exh_clr", {31'b0, exhausted}, 32'h0);
    runUntilIdle(200);

    // Wrap through 0xFFFFFFFF.
    clearLogs();
    startSearch(32'hFFFF_FFFE, 32'h1, 32'h1000);
    runUntilIdle(200);
    checkReqs("r038", 4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1);
    cmp("r038_exhausted", {31'b0, exhausted}, 32'h1);

    // Core stalls for four cycles, then a single-nonce range.
    clearLogs();
    readyMode = 2;
    startSearch(32'h100, 32'h100, 32'h1000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 32'h0);
      cmp("r039_req_held", {31'b0, core_req}, 32'h1);
      cmp("r039_nonce_held", core_nonce, 32'h100);
    end
    readyMode = 1;
    runUntilIdle(200);
    checkReqs("r039", 1, 32'h100, 32'h0, 32'h0, 32'h0);
    cmp("r039_exhausted", {31'b0, exhausted}, 32'h1);

    // Target boundaries.
    clearLogs();
    hashMode = 3;
    startSearch(32'h7, 32'h7, 32'h0);
    runUntilIdle(200);
    cmp("t0_exhausted", {31'b0, exhausted}, 32'h1);
    hashMode = 1;
    startSearch(32'h8, 32'h8, 32'hFFFF_FFFF);
    runUntilIdle(200);
    cmp("tmax_miss_exh", {31'b0, exhausted}, 32'h1);
    hashMode = 4;
    startSearch(32'h9, 32'h9, 32'hFFFF_FFFF);
    runUntilIdle(200);
    cmp("tmax_hit_pulses", 32'(pulseLog.size()), 32'd1);
    if (pulseLog.size() > 0) cmp("tmax_hit_nonce", pulseLog[0], 32'h9);
    cmp("tmax_hit_exh", {31'b0, exhausted}, 32'h0);

    // Abort colliding with a hit.
    clearLogs();
    startSearch(32'h20, 32'h30, 32'hFFFF_FFFF);
    for (int i = 0; i < 20 && !mOutstanding; i++) applyStimulus(1'b0, 1'b0, 2, 32'h0);
    cmp("r040_wait_busy", {31'b0, busy}, 32'h1);
    cmp("r040_wait_req", {31'b0, core_req}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1, 32'h0);
    cmp("r040_abort_valid", {31'b0, valid}, 32'h0);
    cmp("r040_abort_busy", {31'b0, busy}, 32'h0);
    applyStimulus(1'b0, 1'b0, 2, 32'h0);
    cmp("r040_abort_pulses", 32'(pulseLog.size()), 32'd0);

    // Reset while waiting on the core, then a stale result.
    startSearch(32'h40, 32'h50, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 2, 32'h0);
    #2 reset = 1'b1;
    #1;
    cmp("r040_rst_busy", {31'b0, busy}, 32'h0);
    cmp("r040_rst_req", {31'b0, core_req}, 32'h0);
    cmp("r040_rst_core_nonce", core_nonce, 32'h0);
    cmp("r040_rst_valid", {31'b0, valid}, 32'h0);
    cmp("r040_rst_nonce", nonce, 32'h0);
    cmp("r040_rst_exh", {31'b0, exhausted}, 32'h0);
    modelReset();
    @(negedge clk);
    checkOutput();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1, 32'h0);
    applyStimulus(1'b0, 1'b0, 2, 32'h0);
    cmp("r040_late_pulses", 32'(pulseLog.size()), 32'd0);
    cmp("r040_late_busy", {31'b0, busy}, 32'h0);

    // Randomized searches with stray starts, aborts and spurious results.
    hashMode  = 0;
    readyMode = 0;
    randAbort = 1'b1;
    randStart = 1'b1;
    for (int s = 0; s < 60; s++) begin
      logic [31:0] ns;
      logic [31:0] tg;
      ns = ((s % 4) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      case ($urandom_range(0, 3))
        0:       tg = 32'h0;
        1:       tg = 32'hFFFF_FFFF;
        2:       tg = $urandom;
        default: tg = 32'h2000_0000;
      endcase
      startSearch(ns, ns + 32'($urandom_range(0, 5)), tg);
      runUntilIdle(300);
      applyStimulus(1'b0, 1'b0, 0, 32'h0);
    end
    randAbort = 1'b0;
    randStart = 1'b0;
    runUntilIdle(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
